aes_uart_sequencer: RTL and testbench

//  Board-level controller between uart_wrapper and the AES Cipher core.
//  - Assembles 16-byte key and plaintext blocks from the UART RX byte stream; SW[1:0] selects which.
//  - On a BTNC pulse, starts one encryption and waits for done.
//  - Streams the 16 ciphertext bytes back through the UART TX handshake.

---
 rtl/aes_uart_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_aes_uart_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_sequencer.sv
// aes_uart_sequencer: board-level glue between uart_wrapper and the AES Cipher.
// Loads key/plaintext blocks from UART RX, runs one encryption per GO and
// streams the ciphertext back out through the UART TX handshake.
// Ports:
//   CLK, CPU_RESETN        clock, async active-low reset
//   I_MODE, I_GO           SW[1:0] load select, start pulse
//   I_RX_DATA, I_RX_VLD    received byte stream
//   O_TX_DATA, O_TX_START  byte and one-cycle request to the transmitter
//   I_TX_BUSY              transmitter busy
//   O_AES_START            one-cycle Cipher start
//   I_AES_DONE, I_AES_CT   Cipher completion and ciphertext
//   O_AES_PT, O_AES_KEY    plaintext and key registers
//   O_STATE, O_BYTE_CNT    FSM state and byte position, for LEDs
//   O_ERR                  sticky: GO without complete key and plaintext
module aes_uart_sequencer #(
    parameter int NBYTES  = 16,
    parameter int BUSY_TO = 64
) (
    input  logic                CLK,
    input  logic                CPU_RESETN,
    input  logic [1:0]          I_MODE,
    input  logic                I_GO,
    input  logic [7:0]          I_RX_DATA,
    input  logic                I_RX_VLD,
    output logic [7:0]          O_TX_DATA,
    output logic                O_TX_START,
    input  logic                I_TX_BUSY,
    output logic                O_AES_START,
    input  logic                I_AES_DONE,
    input  logic [8*NBYTES-1:0] I_AES_CT,
    output logic [8*NBYTES-1:0] O_AES_PT,
    output logic [8*NBYTES-1:0] O_AES_KEY,
    output logic [2:0]          O_STATE,
    output logic [4:0]          O_BYTE_CNT,
    output logic                O_ERR
);

    localparam int W   = 8 * NBYTES;
    localparam int BW  = $clog2(W);
    localparam int TOW = $clog2(BUSY_TO + 1);

    localparam logic [1:0] MODE_PT  = 2'b01;
    localparam logic [1:0] MODE_KEY = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_TX    = 3'd4,
        S_TXW   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   pt;
    logic [W-1:0]   key;
    logic [W-1:0]   ct;
    logic           pt_ok;
    logic           key_ok;
    logic           err;
    logic [4:0]     byte_cnt;
    logic [1:0]     ld_mode;
    logic [TOW-1:0] to_cnt;
    logic [7:0]     tx_data;
    logic           tx_start;

    logic          mode_ld;
    logic          last;
    logic [BW-1:0] lsb;
    logic          ld_wr;
    logic          ld_done;
    logic          ld_abort;
    logic          go_ok;
    logic          go_bad;
    logic          ct_ld;
    logic          tx_fire;
    logic          drain_adv;

    assign mode_ld = (I_MODE == MODE_PT) || (I_MODE == MODE_KEY);
    assign last    = (byte_cnt == 5'(NBYTES - 1));
    // Byte k lives at bits [W-1-8k -: 8]; first byte is the MSB.
    assign lsb     = BW'(W - 8) - BW'({byte_cnt, 3'b000});

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= S_IDLE;
        else             state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ld_wr     = 1'b0;
        ld_done   = 1'b0;
        ld_abort  = 1'b0;
        go_ok     = 1'b0;
        go_bad    = 1'b0;
        ct_ld     = 1'b0;
        tx_fire   = 1'b0;
        drain_adv = 1'b0;
        case (state)
            S_IDLE: begin
                // GO has priority; a same-cycle RX byte is dropped.
                if (I_GO) begin
                    if (pt_ok && key_ok) begin
                        go_ok   = 1'b1;
                        state_n = S_START;
                    end else begin
                        go_bad = 1'b1;
                    end
                end else if (I_RX_VLD && mode_ld) begin
                    ld_wr   = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (I_MODE != ld_mode) begin
                    ld_abort = 1'b1;
                    state_n  = S_IDLE;
                end else if (I_RX_VLD) begin
                    ld_wr = 1'b1;
                    if (last) begin
                        ld_done = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_START: state_n = S_WAIT;
            S_WAIT: begin
                if (I_AES_DONE) begin
                    ct_ld   = 1'b1;
                    state_n = S_TX;
                end
            end
            S_TX: begin
                if (!I_TX_BUSY) begin
                    tx_fire = 1'b1;
                    state_n = S_TXW;
                end
            end
            S_TXW: begin
                // Move on once the transmitter acknowledges, or give up
                // waiting for busy and treat the byte as taken.
                if (I_TX_BUSY || to_cnt == TOW'(BUSY_TO - 1))
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (!I_TX_BUSY) begin
                    drain_adv = 1'b1;
                    state_n   = last ? S_IDLE : S_TX;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pt       <= '0;
            key      <= '0;
            ct       <= '0;
            pt_ok    <= 1'b0;
            key_ok   <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            ld_mode  <= '0;
            to_cnt   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= tx_fire;
            if (ld_wr) begin
                ld_mode <= I_MODE;
                if (I_MODE == MODE_PT) pt[lsb +: 8]  <= I_RX_DATA;
                else                   key[lsb +: 8] <= I_RX_DATA;
                byte_cnt <= ld_done ? 5'd0 : byte_cnt + 5'd1;
            end
            if (ld_done) begin
                if (I_MODE == MODE_PT) pt_ok  <= 1'b1;
                else                   key_ok <= 1'b1;
            end
            if (ld_abort) begin
                if (ld_mode == MODE_PT) pt_ok  <= 1'b0;
                else                    key_ok <= 1'b0;
                byte_cnt <= '0;
            end
            if (go_ok)  err <= 1'b0;
            if (go_bad) err <= 1'b1;
            if (ct_ld) begin
                ct       <= I_AES_CT;
                byte_cnt <= '0;
            end
            if (tx_fire) begin
                tx_data <= ct[lsb +: 8];
                to_cnt  <= '0;
            end
            if (state == S_TXW) to_cnt <= to_cnt + 1'b1;
            if (drain_adv) byte_cnt <= last ? 5'd0 : byte_cnt + 5'd1;
        end
    end

    assign O_TX_DATA   = tx_data;
    assign O_TX_START  = tx_start;
    assign O_AES_START = (state == S_START);
    assign O_AES_PT    = pt;
    assign O_AES_KEY   = key;
    assign O_STATE     = state;
    assign O_BYTE_CNT  = byte_cnt;
    assign O_ERR       = err;

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// tb_aes_uart_sequencer: randomized self-checking bench for aes_uart_sequencer
// with UART and Cipher stubs and a byte-level reference model.
module tb_aes_uart_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = '0;
    logic         go = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_vld = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         busy = 1'b0;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_ct = '0;
    logic [127:0] aes_pt;
    logic [127:0] aes_key;
    logic [2:0]   state;
    logic [4:0]   byte_cnt;
    logic         err;

    always #5 clk = ~clk;

    aes_uart_sequencer dut (
        .CLK(clk), .CPU_RESETN(rst_n),
        .I_MODE(mode), .I_GO(go),
        .I_RX_DATA(rx_data), .I_RX_VLD(rx_vld),
        .O_TX_DATA(tx_data), .O_TX_START(tx_start),
        .I_TX_BUSY(busy),
        .O_AES_START(aes_start),
        .I_AES_DONE(aes_done), .I_AES_CT(aes_ct),
        .O_AES_PT(aes_pt), .O_AES_KEY(aes_key),
        .O_STATE(state), .O_BYTE_CNT(byte_cnt),
        .O_ERR(err)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic expect_eq(input string tag,
                             input logic [127:0] got,
                             input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART transmitter stub: records each requested byte, stays busy a
    // random few cycles unless silenced (busy never rises).
    logic [7:0]   got_q[$];
    int           viol = 0;
    bit           uart_silent = 0;
    int           bcnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            bcnt = 0;
        end else if (tx_start) begin
            if (busy) viol++;
            got_q.push_back(tx_data);
            if (!uart_silent) begin
                busy = 1'b1;
                bcnt = $urandom_range(2, 8);
            end
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) busy = 1'b0;
        end
    end

    // Cipher stub: done with the preset ciphertext 12 cycles after start.
    logic [127:0] ct_next = '0;
    int           start_cyc = 0;
    int           acnt = 0;

    always @(negedge clk) begin
        aes_done = 1'b0;
        if (!rst_n) begin
            acnt = 0;
        end else if (aes_start) begin
            start_cyc++;
            acnt = 12;
        end else if (acnt > 0) begin
            acnt--;
            if (acnt == 0) begin
                aes_done = 1'b1;
                aes_ct   = ct_next;
            end
        end
    end

    // Reference model: register images and completeness flags.
    logic [127:0] m_pt = '0;
    logic [127:0] m_key = '0;
    bit           m_pt_ok = 0;
    bit           m_key_ok = 0;
    logic [7:0]   blk[16];

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk); #1;
        rx_vld  = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    endtask

    task automatic load(input logic [1:0] md, input int n);
        mode = md;
        for (int i = 0; i < n; i++) begin
            send_rx(blk[i]);
            if (md == 2'b01) m_pt[127-8*i -: 8]  = blk[i];
            else             m_key[127-8*i -: 8] = blk[i];
        end
        if (n == 16) begin
            if (md == 2'b01) m_pt_ok = 1;
            else             m_key_ok = 1;
            cycles(1);
            mode = 2'b00;
        end
    endtask

    task automatic pulse_go();
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic run_enc(input logic [127:0] ct, input bit with_rx);
        int  base;
        int  s0;
        int  cyc;
        bit  done;
        base    = got_q.size();
        s0      = start_cyc;
        ct_next = ct;
        done    = 0;
        cyc     = 0;
        @(posedge clk); #1;
        go = 1'b1;
        if (with_rx) begin
            mode    = 2'b10;
            rx_data = 8'($urandom);
            rx_vld  = 1'b1;
        end
        @(posedge clk); #1;
        go     = 1'b0;
        rx_vld = 1'b0;
        if (with_rx) send_rx(8'($urandom));
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            cyc++;
            if (got_q.size() >= base + 16 && state == 3'd0) begin
                done = 1;
                break;
            end
        end
        mode = 2'b00;
        expect_eq("enc_done", 128'(done), 128'(1));
        expect_eq("aes_start_cnt", 128'(start_cyc - s0), 128'(1));
        expect_eq("err_clear", 128'(err), 128'(0));
        expect_eq("busy_viol", 128'(viol), 128'(0));
        expect_eq("tx_len", 128'(got_q.size() - base), 128'(16));
        if (uart_silent)
            expect_eq("to_len", 128'(cyc >= 16 * 64), 128'(1));
        for (int i = 0; i < 16; i++) begin
            if (base + i < got_q.size())
                expect_eq("tx_byte", 128'(got_q[base+i]),
                          128'((ct >> (8 * (15 - i))) & 128'hff));
        end
        expect_eq("key_kept", aes_key, m_key);
        expect_eq("pt_kept", aes_pt, m_pt);
        expect_eq("cnt_end", 128'(byte_cnt), 128'(0));
    endtask

    initial begin
        int s0;
        int q0;
        bit hit;

        // Reset state
        cycles(3);
        @(negedge clk);
        expect_eq("rst_state", 128'(state), 128'(0));
        expect_eq("rst_err", 128'(err), 128'(0));
        expect_eq("rst_pt", aes_pt, 128'(0));
        expect_eq("rst_key", aes_key, 128'(0));
        expect_eq("rst_tx", 128'({tx_data, tx_start, aes_start}), 128'(0));
        expect_eq("rst_cnt", 128'(byte_cnt), 128'(0));
        rst_n = 1'b1;
        cycles(2);

        // GO without key/plaintext
        pulse_go();
        cycles(3);
        expect_eq("go_nok_err", 128'(err), 128'(1));
        expect_eq("go_nok_state", 128'(state), 128'(0));
        expect_eq("go_nok_start", 128'(start_cyc), 128'(0));

        // Directed key/plaintext load
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        load(2'b10, 7);
        expect_eq("mid_state", 128'(state), 128'(1));
        expect_eq("mid_cnt", 128'(byte_cnt), 128'(7));
        for (int i = 7; i < 16; i++) begin
            send_rx(blk[i]);
            m_key[127-8*i -: 8] = blk[i];
        end
        m_key_ok = 1;
        cycles(1);
        mode = 2'b00;
        expect_eq("key_load", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
        expect_eq("key_cnt", 128'(byte_cnt), 128'(0));
        for (int i = 0; i < 16; i++) blk[i] = 8'(i * 17);
        load(2'b01, 16);
        expect_eq("pt_load", aes_pt, 128'h00112233445566778899aabbccddeeff);
        expect_eq("pt_state", 128'(state), 128'(0));

        // Encryption with the reference ciphertext
        run_enc(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

        // Partial plaintext abort
        fill_rand();
        load(2'b01, 7);
        mode = 2'b00;
        m_pt_ok = 0;
        cycles(2);
        expect_eq("abort_state", 128'(state), 128'(0));
        expect_eq("abort_cnt", 128'(byte_cnt), 128'(0));
        expect_eq("abort_pt", aes_pt, m_pt);
        s0 = start_cyc;
        pulse_go();
        cycles(3);
        expect_eq("abort_err", 128'(err), 128'(1));
        expect_eq("abort_nostart", 128'(start_cyc - s0), 128'(0));

        // Randomized loads and encryptions; second GO reuses registers
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            load(2'b01, 16);
            if (r != 1) begin
                fill_rand();
                load(2'b10, 16);
            end
            expect_eq("rnd_pt", aes_pt, m_pt);
            expect_eq("rnd_key", aes_key, m_key);
            run_enc({$urandom, $urandom, $urandom, $urandom}, r == 2);
            run_enc({$urandom, $urandom, $urandom, $urandom}, 0);
        end

        // Transmitter never signals busy: timeout path
        uart_silent = 1;
        run_enc({$urandom, $urandom, $urandom, $urandom}, 0);
        uart_silent = 0;

        // Reset during transmission of byte 5
        ct_next = {$urandom, $urandom, $urandom, $urandom};
        pulse_go();
        hit = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (byte_cnt == 5'd5 && state == 3'd5) begin
                hit = 1;
                break;
            end
        end
        expect_eq("rst_reach", 128'(hit), 128'(1));
        #2;
        rst_n = 1'b0;
        m_pt = '0; m_key = '0; m_pt_ok = 0; m_key_ok = 0;
        #1;
        expect_eq("arst_state", 128'(state), 128'(0));
        expect_eq("arst_tx", 128'({tx_data, tx_start, aes_start}), 128'(0));
        expect_eq("arst_cnt", 128'(byte_cnt), 128'(0));
        expect_eq("arst_regs", aes_pt | aes_key, 128'(0));
        q0 = got_q.size();
        s0 = start_cyc;
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(200);
        expect_eq("post_rst_tx", 128'(got_q.size() - q0), 128'(0));
        expect_eq("post_rst_aes", 128'(start_cyc - s0), 128'(0));
        expect_eq("post_rst_state", 128'(state), 128'(0));
        pulse_go();
        cycles(3);
        expect_eq("post_rst_err", 128'(err), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
